saw_capture: RTL and testbench

SAW_CAPTURE -- requirements
Module: saw_capture

---
 rtl/saw_capture_pkg.sv | 13 +
 rtl/sync_edge.sv | 21 ++
 rtl/saw_capture.sv | 97 +++++++++
 tb/tb_saw_capture.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/saw_capture_pkg.sv
// saw_capture shared types: FSM state encoding and default widths.
package saw_capture_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    WAIT_FALL,
    DONE
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an async level, plus one history flop
// that turns the synchronized level into rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], din};
  end

  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/saw_capture.sv
// Sawtooth counter that latches its value at the first comparator
// window of each period and publishes the pair at the period wrap.
module saw_capture
  import saw_capture_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PRESC_DIV = 1000
) (
  input  logic             clc_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cmp_i,
  output logic [CNT_W-1:0] sawtooth_cntr_o,
  output logic [CNT_W-1:0] N1_data_o,
  output logic [CNT_W-1:0] N2_data_o,
  output logic             data_valid_o,
  output logic             miss_o
);

  localparam logic [15:0] PMAX = 16'(PRESC_DIV - 1);

  state_t           state;
  logic [15:0]      presc;
  logic [CNT_W-1:0] n1;
  logic [CNT_W-1:0] n2;
  logic             rise;
  logic             fall;
  logic             tick;
  logic             wrap;

  sync_edge u_sync (
    .clk  (clc_i),
    .rst  (rst_i),
    .din  (cmp_i),
    .rise (rise),
    .fall (fall)
  );

  assign tick = en_i && (presc == PMAX);
  assign wrap = tick && (sawtooth_cntr_o == '1);

  always_ff @(posedge clc_i) begin
    if (rst_i) begin
      state           <= IDLE;
      presc           <= '0;
      sawtooth_cntr_o <= '0;
      n1              <= '0;
      n2              <= '0;
      N1_data_o       <= '0;
      N2_data_o       <= '0;
      data_valid_o    <= 1'b0;
      miss_o          <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      miss_o       <= 1'b0;
      if (!en_i) begin
        state           <= IDLE;
        presc           <= '0;
        sawtooth_cntr_o <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) sawtooth_cntr_o <= sawtooth_cntr_o + 1'b1;
        if (state == IDLE) begin
          state <= WAIT_RISE;
        end else if (wrap) begin
          if (state == DONE) begin
            N1_data_o    <= n1;
            N2_data_o    <= n2;
            data_valid_o <= 1'b1;
          end else begin
            miss_o <= 1'b1;
          end
          // an edge on the wrap cycle opens the next period at 0
          if (rise) begin
            n1    <= '0;
            state <= WAIT_FALL;
          end else begin
            state <= WAIT_RISE;
          end
        end else begin
          unique case (state)
            WAIT_RISE: if (rise) begin
              n1    <= sawtooth_cntr_o;
              state <= WAIT_FALL;
            end
            WAIT_FALL: if (fall) begin
              n2    <= sawtooth_cntr_o;
              state <= DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_saw_capture.sv
// Scoreboard bench for saw_capture at PRESC_DIV=4, CNT_W=8.
module tb_saw_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cmp;
  logic [7:0] saw;
  logic [7:0] n1;
  logic [7:0] n2;
  logic       dv;
  logic       miss;

  typedef struct {
    bit valid;
    int n1;
    int n2;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   k;
  int   n_vec = 0;
  int   n_err = 0;

  saw_capture #(.CNT_W(8), .PRESC_DIV(4)) dut (
    .clc_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .cmp_i           (cmp),
    .sawtooth_cntr_o (saw),
    .N1_data_o       (n1),
    .N2_data_o       (n2),
    .data_valid_o    (dv),
    .miss_o          (miss)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // enabled-cycle count since start; counter = k/4 mod 256
  always @(posedge clk) begin
    if (rst || !en) k <= 0;
    else            k <= k + 1;
  end

  always @(negedge clk) begin
    if (dv && miss) chk("both_pulses", 1, 0);
    if (dv || miss) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = q.pop_front();
        chk("kind_valid", int'(dv), int'(e.valid));
        chk("n1", int'(n1), e.n1);
        chk("n2", int'(n2), e.n2);
      end
    end
    if (!rst && en && (k % 64 == 0))
      chk("sawtooth", int'(saw), (k / 4) % 256);
  end

  task automatic wait_k(int t);
    int n = 0;
    while (k != t && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (k != t) chk("timeout", k, t);
  endtask

  task automatic push(bit v, int a, int b);
    exp_t x;
    x.valid = v;
    x.n1    = a;
    x.n2    = b;
    q.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    cmp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_saw", int'(saw), 0);
    chk("rst_n1", int'(n1), 0);
    chk("rst_n2", int'(n2), 0);
    chk("rst_dv", int'(dv), 0);
    chk("rst_miss", int'(miss), 0);
    rst = 1'b0;
    en  = 1'b1;

    push(0, 0, 0);
    push(0, 0, 0);

    wait_k(2048 + 160); cmp = 1'b1;
    push(1, 40, 100);
    wait_k(2048 + 400); cmp = 1'b0;

    push(0, 40, 100);
    wait_k(3072 + 800); cmp = 1'b1;

    push(1, 40, 60);
    wait_k(4096 + 20);  cmp = 1'b0;
    wait_k(4096 + 160); cmp = 1'b1;
    wait_k(4096 + 240); cmp = 1'b0;
    wait_k(4096 + 480); cmp = 1'b1;
    wait_k(4096 + 600); cmp = 1'b0;

    push(0, 40, 60);
    wait_k(5120 + 1021); cmp = 1'b1;

    push(1, 0, 10);
    wait_k(6144 + 40); cmp = 1'b0;

    wait_k(7168 + 120); cmp = 1'b1;
    wait_k(7168 + 320);
    rst = 1'b1;
    cmp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_saw", int'(saw), 0);
    chk("mid_rst_n1", int'(n1), 0);
    chk("mid_rst_n2", int'(n2), 0);
    chk("mid_rst_dv", int'(dv), 0);
    chk("mid_rst_miss", int'(miss), 0);
    chk("queue_at_rst", q.size(), 0);

    push(1, 50, 70);
    wait_k(200); cmp = 1'b1;
    wait_k(280); cmp = 1'b0;
    wait_k(1024 + 10);
    chk("queue_drained", q.size(), 0);

    en = 1'b0;
    @(negedge clk);
    chk("dis_saw", int'(saw), 0);
    chk("dis_n1", int'(n1), 50);
    chk("dis_n2", int'(n2), 70);
    repeat (5) @(negedge clk);
    chk("dis_saw2", int'(saw), 0);
    chk("dis_dv", int'(dv), 0);
    chk("dis_miss", int'(miss), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
